// File: rtl/iir_pkg.sv
// Shared constants and sample types for the IIR output requantizer.
package iir_pkg;

  localparam int IIR_IN_W   = 64;
  localparam int IIR_OUT_W  = 8;
  localparam int IIR_DROP_W = 16;

  // Saturation limits of the 8-bit signed output sample.
  localparam logic signed [IIR_OUT_W-1:0] IIR_SAT_MAX = 8'sh7F;
  localparam logic signed [IIR_OUT_W-1:0] IIR_SAT_MIN = 8'sh80;

  typedef logic signed [IIR_IN_W-1:0]  iir_in_t;
  typedef logic signed [IIR_OUT_W-1:0] iir_out_t;

endpackage

// File: rtl/iir_output_requantizer_if.sv
// Sample stream bundle: filter input side and valid/ready output side.
interface iir_output_requantizer_if
  import iir_pkg::*;
#(
  parameter int IN_W  = IIR_IN_W,
  parameter int OUT_W = IIR_OUT_W
) ();

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/iir_req_fifo.sv
// Synchronous FIFO of ENTRIES samples whose head sits in a registered output slot.
module iir_req_fifo
  import iir_pkg::*;
#(
  parameter int WIDTH   = IIR_OUT_W,
  parameter int ENTRIES = 7,
  parameter int CW      = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(ENTRIES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(ENTRIES);

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push_s, pop_s, load_s;

  // The head slot reloads from memory whenever it is empty or being popped.
  always_comb begin
    push_s    = wr_en_i && (count_q != FULL_CNT);
    pop_s     = rd_en_i && out_valid_q;
    load_s    = (mem_cnt_q != {CW{1'b0}}) && (!out_valid_q || pop_s);
    wr_ptr_d  = push_s ? ((wr_ptr_q == LAST_PTR) ? {PW{1'b0}} : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d  = load_s ? ((rd_ptr_q == LAST_PTR) ? {PW{1'b0}} : rd_ptr_q + 1'b1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CW'(push_s) - CW'(load_s);
    count_d   = count_q + CW'(push_s) - CW'(pop_s);
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
    end else if (pop_s) begin
      out_valid_d = 1'b0;
      out_data_d  = {WIDTH{1'b0}};
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
    end
  end

  // Storage array; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer, count and head-slot registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      mem_cnt_q   <= {CW{1'b0}};
      count_q     <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_data_o  = out_data_q;
  assign rd_valid_o = out_valid_q;
  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == {CW{1'b0}});
  assign count_o    = count_q;

endmodule

// File: rtl/iir_output_requantizer.sv
// Requantizes full-precision IIR samples to 8 bits and buffers them for a valid/ready sink.
// Optional build macro IIR_REQ_ROUND_EN selects round-half-up instead of floor.
module iir_output_requantizer
  import iir_pkg::*;
#(
  parameter int IN_W  = IIR_IN_W,
  parameter int OUT_W = IIR_OUT_W,
  parameter int SHIFT = 8,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  iir_output_requantizer_if.slave bus,
  input  logic                  sat_clr,
  output logic                  sat_flag,
  output logic [IIR_DROP_W-1:0] drop_cnt
);

  localparam int XW     = IN_W + 1;
  localparam int FIFO_N = DEPTH - 1;
  localparam int CW     = $clog2(FIFO_N + 1);
  localparam int OW     = $clog2(DEPTH) + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);
  localparam logic [IIR_DROP_W-1:0] DROP_MAX = {IIR_DROP_W{1'b1}};
  localparam logic signed [XW-1:0] LIM_HI = {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] LIM_LO = {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef IIR_REQ_ROUND_EN
  localparam logic signed [XW-1:0] HALF_LSB = XW'(1) << (SHIFT - 1);
`endif

  // Returns {saturated, sample}; the extra intermediate bit keeps the rounding add from wrapping.
  function automatic logic [OUT_W:0] requant(input logic [IN_W-1:0] x);
    logic signed [XW-1:0] ext_v;
    logic signed [XW-1:0] rnd_v;
    logic signed [XW-1:0] t_v;
    ext_v = {x[IN_W-1], x};
`ifdef IIR_REQ_ROUND_EN
    rnd_v = ext_v + HALF_LSB;
`else
    rnd_v = ext_v;
`endif
    t_v = rnd_v >>> SHIFT;
    if (t_v > LIM_HI) begin
      requant = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (t_v < LIM_LO) begin
      requant = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      requant = {1'b0, t_v[OUT_W-1:0]};
    end
  endfunction

  logic             stage_valid_q, stage_valid_d;
  logic [OUT_W-1:0] stage_data_q, stage_data_d;
  logic             sat_flag_q, sat_flag_d;
  logic [IIR_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [OUT_W:0]   rq_s;
  logic             accept_s, stage_move_s, in_ready_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [CW-1:0]    fifo_count_s;
  logic [OW-1:0]    occ_s;

  // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    occ_s        = OW'(fifo_count_s) + OW'(stage_valid_q);
    in_ready_s   = fifo_empty_s || (occ_s < DEPTH_V);
    accept_s     = bus.in_valid && in_ready_s;
    stage_move_s = stage_valid_q && !fifo_full_s;
    rq_s         = requant(bus.in_data);
    if (accept_s) begin
      stage_valid_d = 1'b1;
      stage_data_d  = rq_s[OUT_W-1:0];
    end else if (stage_move_s) begin
      stage_valid_d = 1'b0;
      stage_data_d  = stage_data_q;
    end else begin
      stage_valid_d = stage_valid_q;
      stage_data_d  = stage_data_q;
    end
    if (accept_s && rq_s[OUT_W]) begin
      sat_flag_d = 1'b1;
    end else if (sat_clr) begin
      sat_flag_d = 1'b0;
    end else begin
      sat_flag_d = sat_flag_q;
    end
    if (bus.in_valid && !in_ready_s && (drop_cnt_q != DROP_MAX)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Requantize stage and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= {OUT_W{1'b0}};
      sat_flag_q    <= 1'b0;
      drop_cnt_q    <= {IIR_DROP_W{1'b0}};
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      sat_flag_q    <= sat_flag_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  iir_req_fifo #(
    .WIDTH   (OUT_W),
    .ENTRIES (FIFO_N),
    .CW      (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (stage_move_s),
    .wr_data_i  (stage_data_q),
    .rd_en_i    (bus.out_ready),
    .rd_data_o  (bus.out_data),
    .rd_valid_o (bus.out_valid),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .count_o    (fifo_count_s)
  );

  assign bus.in_ready = in_ready_s;
  assign sat_flag     = sat_flag_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_iir_output_requantizer.sv
// Directed self-checking bench for iir_output_requantizer (both IIR_REQ_ROUND_EN builds).
module tb_iir_output_requantizer;
  import iir_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sat_clr;
  logic        sat_flag;
  logic [15:0] drop_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef IIR_REQ_ROUND_EN
  localparam logic [7:0] EXP_POS = 8'h13;
  localparam logic [7:0] EXP_NEG = 8'hFF;
`else
  localparam logic [7:0] EXP_POS = 8'h12;
  localparam logic [7:0] EXP_NEG = 8'hFE;
`endif

  iir_output_requantizer_if #(.IN_W(64), .OUT_W(8)) bus ();

  iir_output_requantizer #(.IN_W(64), .OUT_W(8), .SHIFT(8), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sat_clr  (sat_clr),
    .sat_flag (sat_flag),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; sat_clr = 1'b0; bus.in_data = 64'd0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; sat_clr = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = 64'h7FFF_FFFF_FFFF_FFFF;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag got %0b want 0", sat_flag); end
    n_checks++; if (drop_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_drop_cnt got %h want 0000", drop_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_rounding();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_data = 64'h0000_0000_0000_1280; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k0_valid got %0b want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_k1_valid got %0b want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_k2_valid got %0b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== EXP_POS) begin n_fail++; $display("FAIL round_pos got %h want %h", bus.out_data, EXP_POS); end
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL round_pos_nosat got %0b want 0", sat_flag); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL popped_valid got %0b want 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL empty_data got %h want 00", bus.out_data); end
    bus.in_data = 64'hFFFF_FFFF_FFFF_FE80; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    n_checks++; if (bus.out_data !== EXP_NEG || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL round_neg got %h/%0b want %h/1", bus.out_data, bus.out_valid, EXP_NEG); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_data = 64'h7FFF_FFFF_FFFF_FFFF; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got %0b want 1", sat_flag); end
    tick(); tick();
    n_checks++; if (bus.out_data !== 8'h7F) begin n_fail++; $display("FAIL sat_pos_data got %h want 7f", bus.out_data); end
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    n_checks++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_clr_alone got %0b want 0", sat_flag); end
    bus.in_data = 64'hFFFF_FFFF_FFF0_0000; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag got %0b want 1", sat_flag); end
    tick(); tick();
    n_checks++; if (bus.out_data !== 8'h80) begin n_fail++; $display("FAIL sat_neg_data got %h want 80", bus.out_data); end
    tick();
    sat_clr = 1'b1; bus.in_data = 64'h7FFF_FFFF_FFFF_FFFF; bus.in_valid = 1'b1;
    tick();
    sat_clr = 1'b0; bus.in_valid = 1'b0;
    n_checks++; if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins got %0b want 1", sat_flag); end
    tick(); tick(); tick();
  endtask

  task automatic test_full_drop();
    do_reset();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = 64'((i + 1) * 256 + 16);
      tick();
      n_checks++; if (bus.in_ready !== (i < 7)) begin
        n_fail++; $display("FAIL full_in_ready edge %0d got %0b want %0b", i + 1, bus.in_ready, (i < 7)); end
    end
    bus.in_valid = 1'b0;
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL full_drop_cnt got %0d want 4", drop_cnt); end
    n_checks++; if (bus.out_data !== 8'h01 || bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL full_hold got %h/%0b want 01/1", bus.out_data, bus.out_valid); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i + 1)) begin
        n_fail++; $display("FAIL drain_order idx %0d got %h/%0b want %h/1", i, bus.out_data, bus.out_valid, 8'(i + 1)); end
      tick();
      if (i == 0) begin
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL refill_in_ready got %0b want 1", bus.in_ready); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL drain_empty got %h/%0b want 00/0", bus.out_data, bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      bus.in_valid = (e <= 6);
      bus.in_data  = 64'((e + 2) * 256);
      tick();
      if (e >= 3 && e <= 8) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(e)) begin
          n_fail++; $display("FAIL b2b edge %0d got %h/%0b want %h/1", e, bus.out_data, bus.out_valid, 8'(e)); end
      end
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_0100;
    for (int i = 0; i < 65542; i++) tick();
    n_checks++; if (drop_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL drop_fffe got %h want fffe", drop_cnt); end
    tick();
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_ffff got %h want ffff", drop_cnt); end
    for (int i = 0; i < 4458; i++) tick();
    n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_stays got %h want ffff", drop_cnt); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = (i == 2) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'((i + 20) * 256);
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); tick(); tick();
    bus.out_ready = 1'b0;
    n_checks++; if (drop_cnt !== 16'd2 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset got drop %0d sat %0b want 2/1", drop_cnt, sat_flag); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_out got %h/%0b want 00/0", bus.out_data, bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1 || drop_cnt !== 16'd0 || sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state got rdy %0b drop %0d sat %0b want 1/0/0", bus.in_ready, drop_cnt, sat_flag); end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 64'h0000_0000_0000_0500;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale got %h/%0b want 00/0", bus.out_data, bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h05) begin
      n_fail++; $display("FAIL mid_reset_new got %h/%0b want 05/1", bus.out_data, bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_nodup got %0b want 0", bus.out_valid); end
  endtask

  initial begin
    rst = 1'b0; sat_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = 64'd0;
    test_reset();
    test_rounding();
    test_saturation();
    test_full_drop();
    test_back_to_back();
    test_drop_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_output_requantizer.md
# iir_output_requantizer

- Consumer-side stage for the 64-bit IIR filter output: accepts full-precision signed samples, rescales by an arithmetic right shift, saturates to an 8-bit signed sample and buffers it for a valid/ready downstream reader.
- Sits between the filter's `data_out` and any 8-bit sink such as a DAC driver or a serializer.
- The filter produces a sample every clock and cannot stall. The block counts samples it must drop because of backpressure.

## Interface
Parameters:
- `IN_W`, 64, input sample width (signed two's complement)
- `OUT_W`, 8, output sample width (signed)
- `SHIFT`, 8, arithmetic right-shift amount, 1..IN_W-OUT_W
- `DEPTH`, 8, total buffering capacity in samples (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-low (asserted when 0)
- `in_data`  in  IN_W  filter sample
- `in_valid`  in  1  sample present (may be tied 1)
- `in_ready`  out  1  block can accept this cycle
- `out_data`  out  OUT_W  requantized sample
- `out_valid`  out  1  out_data valid
- `out_ready`  in  1  downstream accepts
- `sat_clr`  in  1  clears sat_flag
- `sat_flag`  out  1  sticky: some accepted sample saturated
- `drop_cnt`  out  16  saturating count of rejected samples

## Operation
- **Accept and pop:**
  - A sample is accepted on an edge where `in_valid & in_ready`.
  - A sample is popped on an edge where `out_valid & out_ready`.
- **Requantize stage:**
  - A single registered stage holds `stage_valid` and `stage_data`.
  - The FIFO holds up to DEPTH-1 entries plus the stage, so total occupancy is at most DEPTH.
- **Arithmetic (IN_W+1 bit intermediate, no wrap):**
  - Compute `t = in_data >>> SHIFT`, with rounding applied per Configuration.
  - If `t > 2^(OUT_W-1)-1`, output `0x7F`. If `t < -2^(OUT_W-1)`, output `0x80`. Otherwise output `t[OUT_W-1:0]`.
  - Saturation of an accepted sample sets `sat_flag`.
- **in_ready:**
  - Equals `(occupancy < DEPTH)`, where occupancy is the FIFO count plus `stage_valid`.
  - It is registered-state based and independent of `out_ready` in the same cycle. A pop at full does not enable an accept in that same cycle.
- **drop_cnt:**
  - Increments on each edge with `in_valid & !in_ready`.
  - Saturates at `0xFFFF` and never wraps.
- **sat_flag:**
  - `sat_clr` and a new saturation on the same edge leave `sat_flag = 1` (set wins).
- **Empty output:** `out_data = 0` whenever `out_valid = 0`.
- **Ordering:** samples leave in acceptance order; no reordering or duplication.
- **Simultaneous events:** the stage move into the FIFO, a FIFO pop and a new accept may all occur on one edge. Occupancy is updated by the net change.
- **Reset (including mid-stream):**
  - Reset flushes the stage and FIFO.
  - After the reset edge: `out_valid = 0`, `out_data = 0`, `in_ready = 1`, `sat_flag = 0`, `drop_cnt = 0`.

## Timing
- **Latency:** a sample accepted at edge k into an empty block shows `out_valid = 1` after edge k+2. Cycle k+1 is the requantize register; the FIFO write happens at k+1.
- **Throughput:** one sample per clock sustained while `out_ready = 1`.
- **Backpressure:** `out_valid`/`out_data` hold stable until popped.
- **Refill after full:** the first edge with a pop raises `in_ready` in the following cycle.

## Configuration
- `IIR_REQ_ROUND_EN` defined:
  - Rounding is round-half-up: add `2^(SHIFT-1)` before the shift.
  - `-1.5` rounds to `-1`; `18.5` rounds to `19`.
- `IIR_REQ_ROUND_EN` undefined:
  - Plain arithmetic shift, which is floor/truncation toward −∞.
  - `-1.5` becomes `-2`; `18.5` becomes `18`.

## Structure
- **Shared package `iir_pkg`:**
  - Constants `IIR_IN_W = 64`, `IIR_OUT_W = 8`, `IIR_DROP_W = 16`.
  - Saturation limit constants.
  - Typedefs for the input and output sample types.
- **Sub-module `iir_req_fifo`:** synchronous FIFO with DEPTH-1 entries.
  - Wrap-around read/write pointers plus a count register.
  - Outputs `full`, `empty`, `count`.
- **Top level:** contains the requantize stage, the ready logic and the counters.

## Test plan
- **Rounding, positive:** accept `in_data = 0x1280` (4736), out_ready=1.
  - `out_data = 0x13` (ROUND_EN) or `0x12` (truncate).
  - Appears exactly 2 edges after accept.
- **Rounding, negative:** `in_data = 0xFFFF_FFFF_FFFF_FE80` (−384).
  - `0xFF` (ROUND_EN) or `0xFE` (truncate).
- **Saturation:**
  - `0x7FFF_FFFF_FFFF_FFFF` gives `0x7F`; `0xFFFF_FFFF_FFF0_0000` gives `0x80`. `sat_flag = 1` after each.
  - `sat_clr` alone clears it. `sat_clr` together with a saturating sample keeps it 1.
- **Full/drop:** `out_ready = 0`, `in_valid = 1` for 12 cycles with distinct values.
  - 8 accepted, `in_ready = 0` from cycle 9, `drop_cnt = 4`.
  - Then `out_ready = 1`: the 8 samples leave in order with no gaps.
- **drop_cnt saturation:** `out_ready = 0` with `in_valid = 1` for 70000 cycles.
  - `drop_cnt = 0xFFFF` and stays there.
- **Mid-stream reset:** reset (`rst = 0`) with 5 samples buffered.
  - After the edge: `out_valid = 0`, `out_data = 0`, `in_ready = 1`, counters 0.
  - A new sample appears after 2 edges with no stale data.
